piano_voice_ctrl: RTL and testbench
===================================

# piano_voice_ctrl

Single-voice note controller for the piano datapath. Synchronises and arbitrates the four key inputs, then generates a per-note sample tick from the one system clock instead of switching between gated note clocks. It sequences the 32-entry waveform ROM address and registers the audio sample. Note changes and note-off are deferred to a waveform wrap, so the output never glitches mid-cycle.

## Interface
- DIV_DO, 2988: clk cycles per sample tick for Do (523 Hz × 32 at 50 MHz)
- DIV_RE, 2662: same, Re (587 Hz)
- DIV_MI, 2371: same, Mi (659 Hz)
- DIV_SOL, 1993: same, Sol (784 Hz)
- DB_CYCLES, 500000: stable cycles required per key (debounce build only)
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- keys  in  4  async key levels; bit3=Do, bit2=Re, bit1=Mi, bit0=Sol
- rom_data  in  4  waveform ROM data, combinational from rom_addr
- rom_addr  out  5  waveform ROM address
- sample  out  4  registered audio sample
- sample_tick  out  1  one-cycle pulse per sample step
- active  out  1  high in PLAY or RELEASE
- note  out  2  current note: 3=Do, 2=Re, 1=Mi, 0=Sol

## Operation
- keys pass through a 2-FF synchroniser into ksync.
- Arbitration is fixed priority, Do > Re > Mi > Sol. req = any ksync bit; req_note = index of the highest set bit.
- Divider: 12-bit cnt counts 0..DIV(note)-1. sample_tick=1 when cnt==DIV-1, and cnt returns to 0 on the same edge. cnt is held at 0 in IDLE. DIV values of 2..4095 are legal; 0 and 1 are unsupported.
- On sample_tick: sample <= rom_data (read at the current rom_addr), and rom_addr <= rom_addr+1 modulo 32. Address 31 wraps to 0.
- A wrap is a tick taken while rom_addr==31.
- FSM states: IDLE, PLAY, RELEASE.
- IDLE, req=1 → PLAY: note <= req_note, rom_addr=0, cnt=0.
- PLAY, req=1 with req_note≠note: no immediate effect. At the next wrap, note <= req_note. The new DIV applies from cnt=0 after that edge.
- PLAY, req=0 → RELEASE. The current note keeps playing.
- RELEASE, req=1 → PLAY. note is unchanged; any change of note again waits for a wrap.
- RELEASE, wrap → IDLE: sample <= 0, rom_addr <= 0. The last ROM word read at address 31 is discarded.
- Simultaneous wrap and req change: req sampled on that same edge decides. If req=1 in RELEASE at a wrap, the FSM goes to PLAY with note <= req_note.
- Reset mid-note: the next edge forces IDLE, and all outputs take their reset values.

## Timing
- Reset values: sample=0, rom_addr=0, sample_tick=0, active=0, note=0, cnt=0, ksync=0.
- Key to PLAY: key level stable before edge 0 → ksync valid after edge 2 → active=1 after edge 3.
- First tick: DIV cycles after entering PLAY. The sample reflects ROM[0] one edge after that tick.
- Tick period is exactly DIV(note) cycles, with no jitter, including across a note change at a wrap.
- sample_tick is combinational from cnt/state and is high for one cycle per step.
- Release latency: from 0 to 32×DIV cycles, ending on the wrap edge.

## Configuration
- PIANO_DEBOUNCE_EN
- Defined: each ksync bit feeds a 20-bit debounce counter. A key's debounced level changes only after DB_CYCLES consecutive cycles of the new synchronised level. Arbitration uses the debounced levels. Key-to-PLAY latency becomes DB_CYCLES+3 cycles. Counters clear on rst.
- Undefined: no debounce logic, ksync drives arbitration directly, and DB_CYCLES is ignored.

## Test plan
- Bench DIVs 8/7/6/5 (Do/Re/Mi/Sol), ROM[i]=i[3:0].
- Reset: hold rst 2 cycles with keys=4'b1000 → all outputs 0 and state IDLE during reset; active=1 three cycles after rst falls.
- Single note: keys=4'b1000 held → sample_tick every 8 cycles, and sample sequence 0,1,…,15,0,…,15 over 32 ticks.
- Priority and deferred change: keys=4'b0001, then 4'b0101 at rom_addr=10 → note stays 0, tick period 5 until wrap, then note=2 and period 7 with no short period at the switch.
- Release to wrap: keys drop to 0 at rom_addr=3 → active stays 1 through the tick at addr 31, then sample=0, rom_addr=0, active=0.
- Re-press in RELEASE: keys 0 then 4'b0010 before the wrap → returns to PLAY with no gap in ticks; note changes only at the wrap.
- Debounce build (DB_CYCLES=16): 10-cycle pulse on keys[3] → active stays 0; a 30-cycle press → active=1 at cycle 19.

Source files
------------

// File: rtl/piano_voice_ctrl.sv
// Single-voice piano note controller: key sync/arbitration, per-note sample tick,
// waveform ROM sequencing. Optional key debounce when PIANO_DEBOUNCE_EN is defined.
module piano_voice_ctrl #(
  parameter int DIV_DO    = 2988,
  parameter int DIV_RE    = 2662,
  parameter int DIV_MI    = 2371,
  parameter int DIV_SOL   = 1993,
  parameter int DB_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] keys,
  input  logic [3:0] rom_data,
  output logic [4:0] rom_addr,
  output logic [3:0] sample,
  output logic       sample_tick,
  output logic       active,
  output logic [1:0] note
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PLAY    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam logic [11:0] LAST_DO  = 12'(DIV_DO - 1);
  localparam logic [11:0] LAST_RE  = 12'(DIV_RE - 1);
  localparam logic [11:0] LAST_MI  = 12'(DIV_MI - 1);
  localparam logic [11:0] LAST_SOL = 12'(DIV_SOL - 1);

  state_t      state;
  logic [3:0]  kmeta;
  logic [3:0]  ksync;
  logic [3:0]  klvl;
  logic [11:0] cnt;
  logic [11:0] div_last;
  logic        req;
  logic [1:0]  req_note;
  logic        wrap;

  always_ff @(posedge clk) begin
    if (rst) begin
      kmeta <= '0;
      ksync <= '0;
    end else begin
      kmeta <= keys;
      ksync <= kmeta;
    end
  end

`ifdef PIANO_DEBOUNCE_EN
  localparam logic [19:0] DB_LAST = 20'(DB_CYCLES - 1);

  logic [19:0] db_cnt [4];

  // A key's level flips only after DB_CYCLES consecutive cycles of disagreement.
  always_ff @(posedge clk) begin
    if (rst) begin
      klvl <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (ksync[i] == klvl[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          klvl[i]   <= ksync[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 20'd1;
        end
      end
    end
  end
`else
  logic unused_db;
  assign unused_db = (DB_CYCLES != 0);
  assign klvl      = ksync;
`endif

  always_comb begin
    req      = |klvl;
    req_note = 2'd0;
    if (klvl[3])      req_note = 2'd3;
    else if (klvl[2]) req_note = 2'd2;
    else if (klvl[1]) req_note = 2'd1;
  end

  always_comb begin
    case (note)
      2'd3:    div_last = LAST_DO;
      2'd2:    div_last = LAST_RE;
      2'd1:    div_last = LAST_MI;
      default: div_last = LAST_SOL;
    endcase
  end

  assign sample_tick = (state != IDLE) && (cnt == div_last);
  assign wrap        = sample_tick && (rom_addr == 5'd31);
  assign active      = (state != IDLE);

  // Note changes and note-off only take effect on a wrap, so a waveform
  // period is never cut short.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      note     <= 2'd0;
      cnt      <= '0;
      rom_addr <= '0;
      sample   <= '0;
    end else begin
      if (state != IDLE) begin
        cnt <= sample_tick ? 12'd0 : cnt + 12'd1;
        if (sample_tick) begin
          sample   <= rom_data;
          rom_addr <= rom_addr + 5'd1;
        end
      end
      case (state)
        IDLE: begin
          cnt <= '0;
          if (req) begin
            state    <= PLAY;
            note     <= req_note;
            rom_addr <= '0;
          end
        end
        PLAY, RELEASE: begin
          if (wrap && !req) begin
            state    <= IDLE;
            sample   <= '0;
            rom_addr <= '0;
          end else if (wrap) begin
            state <= PLAY;
            note  <= req_note;
          end else if (req) begin
            state <= PLAY;
          end else begin
            state <= RELEASE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_piano_voice_ctrl.sv
// Bench for piano_voice_ctrl with DIVs 8/7/6/5 and ROM[i]=i[3:0]; build with
// PIANO_DEBOUNCE_EN to exercise the debounce path instead of the note sequences.
module tb_piano_voice_ctrl;
  localparam int W = 12;

  logic       clk;
  logic       rst;
  logic [3:0] keys;
  logic [3:0] rom_data;
  logic [4:0] rom_addr;
  logic [3:0] sample;
  logic       sample_tick;
  logic       active;
  logic [1:0] note;

  piano_voice_ctrl #(
    .DIV_DO(8), .DIV_RE(7), .DIV_MI(6), .DIV_SOL(5), .DB_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst), .keys(keys), .rom_data(rom_data),
    .rom_addr(rom_addr), .sample(sample), .sample_tick(sample_tick),
    .active(active), .note(note)
  );

  assign rom_data = rom_addr[3:0];

  // entry: [11:8] period since previous tick, [5:4] note at tick, [3:0] sample after tick
  logic [W-1:0] exp_q[$];
  int   n_checks  = 0;
  int   n_bad     = 0;
  int   tick_cnt  = 0;
  int   cyc       = 0;
  int   last_tick = 0;
  bit   mon_en    = 0;
  bit   pend      = 0;
  bit   act_prev  = 0;
  logic [3:0] exp_sample;

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d want=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input int period, input int nt, input int smp);
    return {4'(period), 2'b00, 2'(nt), 4'(smp)};
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    logic [W-1:0] e;
    cyc++;
    if (pend) begin
      check_eq("sample", 32'(sample), 32'(exp_sample));
      pend = 0;
    end
    if (active === 1'b1 && !act_prev) last_tick = cyc - 1;
    act_prev = (active === 1'b1);
    if (mon_en && sample_tick === 1'b1) begin
      tick_cnt++;
      if (exp_q.size() == 0) begin
        check_eq("tick_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("period", 32'(cyc - last_tick), 32'(e[11:8]));
        check_eq("note_at_tick", 32'(note), 32'(e[5:4]));
        exp_sample = e[3:0];
        pend = 1;
      end
      last_tick = cyc;
    end
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_ticks_to(input int target, input int budget);
    int k = 0;
    while (tick_cnt < target && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (tick_cnt < target) check_eq("tick_timeout", 32'(tick_cnt), 32'(target));
    step(1);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (active !== 1'b0 && k < budget) begin
      step(1);
      k++;
    end
    if (active !== 1'b0) check_eq("idle_timeout", 32'(active), 32'd0);
  endtask

  task automatic push_run(input int period, input int nt, input int from, input int to,
                          input bit last_zero);
    for (int i = from; i <= to; i++)
      exp_q.push_back(mk(period, nt, (last_zero && i == 31) ? 0 : i % 16));
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_sample"}, 32'(sample), 32'd0);
    check_eq({tag, "_addr"}, 32'(rom_addr), 32'd0);
    check_eq({tag, "_tick"}, 32'(sample_tick), 32'd0);
    check_eq({tag, "_active"}, 32'(active), 32'd0);
    check_eq({tag, "_state"}, 32'(dut.state), 32'd0);
  endtask

  initial begin
    int base;
    rst  = 1'b1;
    keys = 4'b0000;
`ifdef PIANO_DEBOUNCE_EN
    begin
      bit seen = 0;
      step(2);
      rst = 1'b0;
      step(2);
      keys = 4'b1000;
      step(10);
      keys = 4'b0000;
      for (int i = 0; i < 40; i++) begin
        step(1);
        seen |= (active === 1'b1);
      end
      check_eq("db_glitch_active", 32'(seen), 32'd0);
      keys = 4'b1000;
      step(18);
      check_eq("db_active_18", 32'(active), 32'd0);
      step(1);
      check_eq("db_active_19", 32'(active), 32'd1);
      check_eq("db_note", 32'(note), 32'd3);
      step(11);
      keys = 4'b0000;
      step(2);
    end
`else
    // reset with Do held, then single note and release at rom_addr 3
    keys   = 4'b1000;
    mon_en = 1;
    push_run(8, 3, 0, 34, 0);
    for (int i = 0; i < 2; i++) begin
      step(1);
      check_idle_outputs("reset");
      check_eq("reset_note", 32'(note), 32'd0);
    end
    rst = 1'b0;
    step(2);
    check_eq("active_edge2", 32'(active), 32'd0);
    step(1);
    check_eq("active_edge3", 32'(active), 32'd1);
    check_eq("note_do", 32'(note), 32'd3);
    wait_ticks_to(35, 600);
    check_eq("addr_at_release", 32'(rom_addr), 32'd3);
    keys = 4'b0000;
    push_run(8, 3, 3, 31, 1);
    step(20);
    check_eq("release_active", 32'(active), 32'd1);
    check_eq("release_state", 32'(dut.state), 32'd2);
    wait_idle(400);
    check_idle_outputs("after_release");
    check_eq("queue_a", 32'(exp_q.size()), 32'd0);

    // priority, deferred change, re-press in RELEASE
    base = tick_cnt;
    keys = 4'b0001;
    push_run(5, 0, 0, 31, 0);
    wait_ticks_to(base + 10, 200);
    check_eq("addr10", 32'(rom_addr), 32'd10);
    keys = 4'b0101;
    push_run(7, 2, 0, 31, 0);
    step(4);
    check_eq("note_deferred", 32'(note), 32'd0);
    wait_ticks_to(base + 36, 400);
    check_eq("re_addr4", 32'(rom_addr), 32'd4);
    check_eq("note_re", 32'(note), 32'd2);
    keys = 4'b0000;
    step(5);
    check_eq("repress_state_rel", 32'(dut.state), 32'd2);
    check_eq("repress_active", 32'(active), 32'd1);
    keys = 4'b0010;
    push_run(6, 1, 0, 2, 0);
    step(4);
    check_eq("repress_state_play", 32'(dut.state), 32'd1);
    check_eq("repress_note_kept", 32'(note), 32'd2);
    wait_ticks_to(base + 67, 400);
    check_eq("mi_addr3", 32'(rom_addr), 32'd3);
    check_eq("note_mi", 32'(note), 32'd1);
    keys = 4'b0000;
    push_run(6, 1, 3, 31, 1);
    wait_idle(400);
    check_idle_outputs("after_mi");
    check_eq("queue_b", 32'(exp_q.size()), 32'd0);

    // reset in the middle of a note
    base = tick_cnt;
    keys = 4'b1000;
    push_run(8, 3, 0, 2, 0);
    wait_ticks_to(base + 3, 100);
    mon_en = 0;
    rst    = 1'b1;
    keys   = 4'b0000;
    step(1);
    check_idle_outputs("mid_reset");
    check_eq("mid_reset_note", 32'(note), 32'd0);
    rst = 1'b0;
    exp_q.delete();
    step(5);
    check_eq("post_reset_active", 32'(active), 32'd0);
`endif
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
